score_seg7_scanner: RTL and testbench
=====================================

Name: score_seg7_scanner

Overview:
- Downstream consumer of the game core's 14-bit score counter; drives the board's 4-digit multiplexed 7-segment display.
- Converts binary to BCD sequentially (double-dabble, one bit per cycle) and latches the four digits atomically.
- Scans the digits with a prescaled one-hot common select and optionally blanks leading zeros.
- Single clock domain; no handshake with the producer: re-converts whenever the input differs from the last converted value.

Parameters:
- SCAN_DIV, 2000, clock cycles each digit is shown (>=2).
- BLANK_LZ, 1, 1 = blank leading zero digits (ones digit never blanked).
- SEG_ACTIVE_LOW, 1, 1 = SEG7OUT segments lit when 0; 0 = lit when 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset: synchronous, active-high.
- VALUE  in  14  binary score from the game core. Values above 9999 saturate.
- SEG7OUT  out  7  segment drive, bit0=a … bit6=g, polarity per SEG_ACTIVE_LOW.
- SEG7COM  out  4  digit select, one-hot active-high; bit0=ones, bit3=thousands.
- BUSY  out  1  conversion in progress.
- SAT  out  1  last converted VALUE was >9999.

Behaviour:
- Reset (RST=1 at a CLK edge, including mid-conversion or mid-scan):
  - Converter to IDLE, BUSY=0, SAT=0.
  - Shadow value=0 and all display digits=0.
  - Scan counter=0, digit index=0.
  - SEG7OUT=all segments off, SEG7COM=4'b0000 (one cycle).
  - Any in-flight conversion is discarded.
- Converter FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: if VALUE != shadow, capture sat(VALUE) (=9999 if VALUE>9999) into the shift register, set shadow=VALUE, latch the SAT flag, BUSY<=1, go to SHIFT with bit count 0.
  - SHIFT: once per cycle, add 3 to every BCD nibble >=5, then shift left by one pulling in the next binary MSB. After 14 shifts, go to COMMIT.
  - COMMIT: copy the 16-bit BCD to the display digits in the same edge for all four digits, BUSY<=0, go to IDLE.
  - Latency: capture edge E0, shifts E1..E14, digits visible after E15. BUSY is high after E0 through E15 exclusive.
  - VALUE changes during SHIFT/COMMIT are ignored. The IDLE compare restarts conversion on the cycle after COMMIT, so the final value is always displayed.
  - The display holds the old digits throughout conversion: no glitch or partial value.
- Scanner:
  - The scan counter counts 0..SCAN_DIV-1 and wraps.
  - At the wrap, the digit index advances 0→1→2→3→0.
  - SEG7COM = 1 << index, registered; SEG7OUT is registered in the same cycle (aligned with COM, one cycle after the index changes).
  - From the first edge after reset, COM = 0001.
- Blanking (BLANK_LZ=1): digit k (k>=1) is blank if it and all higher digits are 0. Blank means all segments off, while COM still asserts.
- Encoding (active-high form, gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - SEG_ACTIVE_LOW inverts the pattern. Nibbles >9 cannot occur; if seen, show blank.

Decomposition:
- Shared package seg7_pkg: 7-bit digit-pattern constants for 0-9 and blank, MAX_SCORE=9999, digit-count constant 4.
- Sub-module bin14_to_bcd4: converter FSM, with ports CLK, RST, VALUE, BCD[15:0], BUSY, SAT.
- Top level holds the scanner, blanking and encoding.

Test Plan:
- Reset: hold RST 3 cycles with VALUE=0 → SEG7COM=0000 then 0001, SEG7OUT=all off, BUSY=0, SAT=0.
- Basic conversion: VALUE 0→1234 → BUSY rises the cycle after the change and drops 15 cycles later. With SCAN_DIV=4 the scan shows ones=4, tens=3, hundreds=2, thousands=1; active-low ones pattern 1100110 inverted = 0011001.
- Saturation and SAT flag:
  - VALUE=12000 → digits 9,9,9,9, SAT=1.
  - Then VALUE=100 → SAT=0, thousands blank, hundreds=1, tens=0 shown, ones=0 shown.
- Mid-conversion change: VALUE=5 then VALUE=77 on the 5th SHIFT cycle → display shows 5 after the first COMMIT, then a second conversion starts the next cycle and shows 77. No other value is ever displayed.
- Reset mid-conversion: RST pulse during SHIFT with VALUE=42 → digits stay 0 after reset; conversion of 42 restarts from IDLE and completes 15 cycles after capture.
- Blanking off and wrap: BLANK_LZ=0, VALUE=7 → COM cycles 0001,0010,0100,1000,0001 every SCAN_DIV cycles, showing 0,0,0 and 7 on the ones digit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the score display: digit patterns,
// score limit and the converter state encoding.
package seg7_pkg;

  localparam int          NUM_DIGITS = 4;
  localparam logic [13:0] MAX_SCORE  = 14'd9999;

  // Active-high segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_e;

  // Non-decimal nibbles render as blank rather than garbage.
  function automatic logic [6:0] seg7_encode(input logic [3:0] digit);
    logic [6:0] pat;
    case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [15:0] bcd_add3(input logic [15:0] bcd);
    logic [15:0] res;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin14_to_bcd4.sv
// Sequential 14-bit binary to 4-digit BCD converter (one bit per cycle).
// The BCD output only changes at COMMIT, so consumers never see a partial result.
module bin14_to_bcd4
  import seg7_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [13:0] VALUE,
  output logic [15:0] BCD,
  output logic        BUSY,
  output logic        SAT
);

  conv_state_e state_r, state_s;
  logic [13:0] shadow_r, shadow_s;
  logic [13:0] bin_r, bin_s;
  logic [15:0] bcd_r, bcd_s;
  logic [15:0] bcd_out_r, bcd_out_s;
  logic [15:0] adj_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        busy_r, busy_s;
  logic        sat_r, sat_s;

  // Converter state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= CONV_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Converter datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_r  <= 14'd0;
      bin_r     <= 14'd0;
      bcd_r     <= 16'd0;
      bcd_out_r <= 16'd0;
      cnt_r     <= 4'd0;
      busy_r    <= 1'b0;
      sat_r     <= 1'b0;
    end else begin
      shadow_r  <= shadow_s;
      bin_r     <= bin_s;
      bcd_r     <= bcd_s;
      bcd_out_r <= bcd_out_s;
      cnt_r     <= cnt_s;
      busy_r    <= busy_s;
      sat_r     <= sat_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s   = state_r;
    shadow_s  = shadow_r;
    bin_s     = bin_r;
    bcd_s     = bcd_r;
    bcd_out_s = bcd_out_r;
    cnt_s     = cnt_r;
    busy_s    = busy_r;
    sat_s     = sat_r;
    adj_s     = bcd_add3(bcd_r);
    case (state_r)
      CONV_IDLE: begin
        if (VALUE != shadow_r) begin
          shadow_s = VALUE;
          sat_s    = (VALUE > MAX_SCORE);
          bin_s    = (VALUE > MAX_SCORE) ? MAX_SCORE : VALUE;
          bcd_s    = 16'd0;
          cnt_s    = 4'd0;
          busy_s   = 1'b1;
          state_s  = CONV_SHIFT;
        end else begin
          state_s  = CONV_IDLE;
        end
      end
      CONV_SHIFT: begin
        {bcd_s, bin_s} = {adj_s[14:0], bin_r, 1'b0};
        cnt_s = cnt_r + 4'd1;
        if (cnt_r == 4'd13) begin
          state_s = CONV_COMMIT;
        end else begin
          state_s = CONV_SHIFT;
        end
      end
      CONV_COMMIT: begin
        bcd_out_s = bcd_r;
        busy_s    = 1'b0;
        state_s   = CONV_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = CONV_IDLE;
      end
    endcase
  end

  assign BCD  = bcd_out_r;
  assign BUSY = busy_r;
  assign SAT  = sat_r;

endmodule

// File: rtl/score_seg7_scanner.sv
// 4-digit multiplexed 7-segment driver for the game score: BCD conversion,
// prescaled digit scan, optional leading-zero blanking and segment encoding.
module score_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 2000,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [13:0] VALUE,
  output logic [6:0]  SEG7OUT,
  output logic [3:0]  SEG7COM,
  output logic        BUSY,
  output logic        SAT
);

  localparam int             CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]     SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [15:0]           bcd_s;
  logic [CNT_W-1:0]      scan_cnt_r;
  logic [1:0]            digit_idx_r;
  logic [3:0]            com_r;
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] blank_s;
  logic                  zero3_s, zero2_s, zero1_s;
  logic [3:0]            digit_s;
  logic [6:0]            pat_s;
  logic [6:0]            seg_s;

  bin14_to_bcd4 u_conv (
    .CLK   (CLK),
    .RST   (RST),
    .VALUE (VALUE),
    .BCD   (bcd_s),
    .BUSY  (BUSY),
    .SAT   (SAT)
  );

  // Leading-zero blanking: a digit is blank when it and every higher digit are zero
  always_comb begin
    zero3_s = (bcd_s[15:12] == 4'd0);
    zero2_s = zero3_s && (bcd_s[11:8] == 4'd0);
    zero1_s = zero2_s && (bcd_s[7:4] == 4'd0);
    if (BLANK_LZ) begin
      blank_s = {zero3_s, zero2_s, zero1_s, 1'b0};
    end else begin
      blank_s = 4'b0000;
    end
  end

  // Select the current digit and encode it to the panel polarity
  always_comb begin
    case (digit_idx_r)
      2'd0:    digit_s = bcd_s[3:0];
      2'd1:    digit_s = bcd_s[7:4];
      2'd2:    digit_s = bcd_s[11:8];
      2'd3:    digit_s = bcd_s[15:12];
      default: digit_s = 4'd0;
    endcase
    if (blank_s[digit_idx_r]) begin
      pat_s = SEG_BLANK;
    end else begin
      pat_s = seg7_encode(digit_s);
    end
    if (SEG_ACTIVE_LOW) begin
      seg_s = ~pat_s;
    end else begin
      seg_s = pat_s;
    end
  end

  // Scan prescaler, digit index and registered segment/common drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt_r  <= '0;
      digit_idx_r <= 2'd0;
      com_r       <= 4'b0000;
      seg_r       <= SEG_OFF;
    end else begin
      if (scan_cnt_r == CNT_LAST) begin
        scan_cnt_r  <= '0;
        digit_idx_r <= digit_idx_r + 2'd1;
      end else begin
        scan_cnt_r  <= scan_cnt_r + CNT_W'(1);
      end
      com_r <= 4'b0001 << digit_idx_r;
      seg_r <= seg_s;
    end
  end

  assign SEG7OUT = seg_r;
  assign SEG7COM = com_r;

endmodule

// File: tb/tb_score_seg7_scanner.sv
// Directed bench for score_seg7_scanner: table of score values plus
// hand-written sequences for mid-conversion change, mid-conversion reset and scan wrap.
module tb_score_seg7_scanner;

  localparam int SCAN_DIV = 4;

  typedef struct {
    logic [13:0] value;
    logic [15:0] dig;    // thousands..ones nibbles
    logic [3:0]  blank;  // bit k: digit k expected blank (blanking instance)
    logic        sat;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic [13:0] VALUE;
  logic [6:0]  seg_a, seg_b;
  logic [3:0]  com_a, com_b;
  logic        busy_a, busy_b, sat_a, sat_b;

  int n_cmp = 0;
  int n_bad = 0;

  score_seg7_scanner #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLK(CLK), .RST(RST), .VALUE(VALUE),
    .SEG7OUT(seg_a), .SEG7COM(com_a), .BUSY(busy_a), .SAT(sat_a)
  );

  score_seg7_scanner #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_nb (
    .CLK(CLK), .RST(RST), .VALUE(VALUE),
    .SEG7OUT(seg_b), .SEG7COM(com_b), .BUSY(busy_b), .SAT(sat_b)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [6:0] pat_hi(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Active-low panel: blank is all ones.
  function automatic logic [6:0] exp_seg(input logic [3:0] nib, input logic blk);
    if (blk) return 7'h7F;
    return ~pat_hi(nib);
  endfunction

  function automatic bit disp_ok(input logic [3:0] com, input logic [6:0] seg,
                                 input logic [15:0] dig, input logic [3:0] blank);
    int k;
    k = -1;
    for (int i = 0; i < 4; i++) if (com === 4'(1 << i)) k = i;
    if (k < 0) return 1'b0;
    return seg === exp_seg(dig[4*k +: 4], blank[k]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Apply a new value; check BUSY latency and that the old digits hold meanwhile.
  task automatic convert(input logic [13:0] v, input logic [15:0] odig,
                         input logic [3:0] oblk, input string nm);
    int cyc;
    bit hold_ok;
    VALUE = v;
    tick();
    check({nm, " busy rise"}, busy_a, 1'b1);
    cyc = 0;
    hold_ok = 1'b1;
    while (busy_a === 1'b1 && cyc < 40) begin
      if (!disp_ok(com_a, seg_a, odig, oblk)) hold_ok = 1'b0;
      if (!disp_ok(com_b, seg_b, odig, 4'b0000)) hold_ok = 1'b0;
      tick();
      cyc++;
    end
    if (!disp_ok(com_a, seg_a, odig, oblk)) hold_ok = 1'b0;
    check({nm, " busy cycles"}, cyc, 15);
    check({nm, " hold old digits"}, hold_ok, 1'b1);
  endtask

  // Observe one full scan on both instances and compare every digit.
  task automatic scan(input logic [15:0] dig, input logic [3:0] blank, input string nm);
    logic [6:0] cap_a [4];
    logic [6:0] cap_b [4];
    bit onehot_ok;
    for (int k = 0; k < 4; k++) begin
      cap_a[k] = 7'bxxxxxxx;
      cap_b[k] = 7'bxxxxxxx;
    end
    onehot_ok = 1'b1;
    tick();
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      if (!$onehot(com_a) || !$onehot(com_b)) onehot_ok = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (com_a === 4'(1 << i)) cap_a[i] = seg_a;
        if (com_b === 4'(1 << i)) cap_b[i] = seg_b;
      end
      tick();
    end
    check({nm, " com onehot"}, onehot_ok, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s blank-on digit%0d", nm, k), cap_a[k], exp_seg(dig[4*k +: 4], blank[k]));
      check($sformatf("%s blank-off digit%0d", nm, k), cap_b[k], exp_seg(dig[4*k +: 4], 1'b0));
    end
  endtask

  initial begin
    vec_t vecs [8];
    logic [15:0] prev_dig;
    logic [3:0]  prev_blk;
    logic [3:0]  prev_com;
    int cyc;
    bit ok;
    bit found;

    vecs[0] = '{14'd1234,  16'h1234, 4'b0000, 1'b0};
    vecs[1] = '{14'd12000, 16'h9999, 4'b0000, 1'b1};
    vecs[2] = '{14'd100,   16'h0100, 4'b1000, 1'b0};
    vecs[3] = '{14'd10000, 16'h9999, 4'b0000, 1'b1};
    vecs[4] = '{14'd9999,  16'h9999, 4'b0000, 1'b0};
    vecs[5] = '{14'd1005,  16'h1005, 4'b0000, 1'b0};
    vecs[6] = '{14'd50,    16'h0050, 4'b1100, 1'b0};
    vecs[7] = '{14'd7,     16'h0007, 4'b1110, 1'b0};

    // Reset
    RST = 1'b1;
    VALUE = 14'd0;
    repeat (3) tick();
    check("reset com", com_a, 4'b0000);
    check("reset seg", seg_a, 7'h7F);
    check("reset busy", busy_a, 1'b0);
    check("reset sat", sat_a, 1'b0);
    check("reset com nb", com_b, 4'b0000);
    RST = 1'b0;
    tick();
    check("first com", com_a, 4'b0001);
    check("first seg zero", seg_a, 7'b1000000);
    check("idle busy", busy_a, 1'b0);

    // Table-driven conversions
    prev_dig = 16'h0000;
    prev_blk = 4'b1110;
    for (int v = 0; v < 8; v++) begin
      string nm;
      nm = $sformatf("v%0d", vecs[v].value);
      convert(vecs[v].value, prev_dig, prev_blk, nm);
      check({nm, " sat"}, sat_a, vecs[v].sat);
      check({nm, " sat nb"}, sat_b, vecs[v].sat);
      scan(vecs[v].dig, vecs[v].blank, nm);
      prev_dig = vecs[v].dig;
      prev_blk = vecs[v].blank;
    end

    // Mid-conversion change: 5, then 77 during the 5th shift
    VALUE = 14'd5;
    tick();
    check("mid busy rise", busy_a, 1'b1);
    repeat (5) tick();
    VALUE = 14'd77;
    cyc = 5;
    while (busy_a === 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("mid first busy cycles", cyc, 15);
    tick();
    check("mid restart busy", busy_a, 1'b1);
    ok = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (!disp_ok(com_a, seg_a, 16'h0005, 4'b1110)) ok = 1'b0;
      if (!disp_ok(com_b, seg_b, 16'h0005, 4'b0000)) ok = 1'b0;
      tick();
    end
    check("mid shows 5 only", ok, 1'b1);
    cyc = 0;
    while (busy_a === 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("mid second done", busy_a, 1'b0);
    scan(16'h0077, 4'b1100, "v77");

    // Reset during SHIFT with VALUE=42
    VALUE = 14'd42;
    tick();
    repeat (3) tick();
    RST = 1'b1;
    tick();
    check("midrst busy", busy_a, 1'b0);
    check("midrst com", com_a, 4'b0000);
    check("midrst seg", seg_a, 7'h7F);
    check("midrst sat", sat_a, 1'b0);
    RST = 1'b0;
    convert(14'd42, 16'h0000, 4'b1110, "rst42");
    scan(16'h0042, 4'b1100, "v42");

    // Blanking off and scan wrap on the non-blanking instance
    convert(14'd7, 16'h0042, 4'b1100, "v7b");
    scan(16'h0007, 4'b1110, "v7b");
    found = 1'b0;
    prev_com = com_b;
    cyc = 0;
    while (!found && cyc < 4 * SCAN_DIV + 4) begin
      tick();
      cyc++;
      if (prev_com === 4'b1000 && com_b === 4'b0001) found = 1'b1;
      else prev_com = com_b;
    end
    check("wrap sync", found, 1'b1);
    for (int step = 0; step < 5; step++) begin
      logic [15:0] d7;
      d7 = 16'h0007;
      ok = 1'b1;
      for (int s = 0; s < SCAN_DIV; s++) begin
        if (com_b !== 4'(1 << (step % 4))) ok = 1'b0;
        if (seg_b !== exp_seg(d7[4*(step%4) +: 4], 1'b0)) ok = 1'b0;
        tick();
      end
      check($sformatf("wrap step%0d", step), ok, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
